param_updown_counter: RTL and testbench

//  Next-generation counter for the TT tile: parametrised width, programmable limit and step.

---
 rtl/param_counter_pkg.sv | 17 +
 rtl/counter_prescaler.sv | 39 +++
 rtl/param_updown_counter.sv | 135 +++++++++++++
 tb/tb_param_updown_counter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/param_counter_pkg.sv
// Shared definitions for the parametrised up/down counter and its prescaler.
// The optional capture register is enabled by the PARAM_COUNTER_CAPTURE_EN macro.
package param_counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_PP   = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    // A zero step advances by one; the result is wide enough for any 16-bit step.
    function automatic logic [16:0] norm_step(input logic [15:0] step);
        return (step == '0) ? 17'd1 : {1'b0, step};
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable-gated prescaler: tick is high on every (presc+1)-th enabled cycle.
// PRESC_W=0 degenerates to a permanent tick.
module counter_prescaler #(
    parameter int unsigned PRESC_W = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      en,
    input  logic [((PRESC_W > 0) ? PRESC_W : 1)-1:0]  presc,
    input  logic                                      clear,
    output logic                                      tick
);

    generate
        if (PRESC_W == 0) begin : g_no_presc
            logic unused_presc;
            assign unused_presc = ^{clk, rst_n, en, presc, clear};
            assign tick = 1'b1;
        end else begin : g_presc
            logic [PRESC_W-1:0] cnt;

            assign tick = (cnt == presc);

            // A count left above a newly lowered presc restarts regardless of en.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (cnt > presc) begin
                    cnt <= '0;
                end else if (en) begin
                    cnt <= (cnt == presc) ? '0 : cnt + PRESC_W'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/param_updown_counter.sv
// Counter with up-wrap, down-wrap, ping-pong and hold modes, load, prescaled advance
// and a terminal-count pulse; PARAM_COUNTER_CAPTURE_EN adds the cap_val snapshot register.
module param_updown_counter
    import param_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned STEP_W    = 4,
    parameter int unsigned PRESC_W   = 4,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      en,
    input  logic                                      load,
    input  logic [WIDTH-1:0]                          load_val,
    input  logic [1:0]                                mode,
    input  logic [STEP_W-1:0]                         step,
    input  logic [WIDTH-1:0]                          limit,
    input  logic [((PRESC_W > 0) ? PRESC_W : 1)-1:0]  presc,
    input  logic                                      capture,
    output logic [WIDTH-1:0]                          count,
    output logic                                      dir,
    output logic                                      tc,
    output logic [WIDTH-1:0]                          cap_val
);

    logic             tick;
    logic             advance;
    logic [16:0]      s;
    logic [16:0]      cnt_x;
    logic [16:0]      lim_x;
    logic [16:0]      sum;
    logic [16:0]      diff;
    logic [WIDTH-1:0] next_count;
    logic             next_dir;
    logic             next_tc;

    counter_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .presc (presc),
        .clear (load),
        .tick  (tick)
    );

    assign advance = en & tick;
    assign s       = norm_step(16'(step));
    assign cnt_x   = 17'(count);
    assign lim_x   = 17'(limit);
    assign sum     = cnt_x + s;
    assign diff    = cnt_x - s;

    always_comb begin
        next_count = count;
        next_dir   = dir;
        next_tc    = 1'b0;
        if (advance) begin
            case (mode_e'(mode))
                MODE_UP: begin
                    next_dir = 1'b0;
                    if (sum > lim_x) begin
                        next_count = '0;
                        next_tc    = 1'b1;
                    end else begin
                        next_count = sum[WIDTH-1:0];
                    end
                end
                MODE_DOWN: begin
                    next_dir = 1'b0;
                    if (cnt_x < s) begin
                        next_count = limit;
                        next_tc    = 1'b1;
                    end else begin
                        next_count = diff[WIDTH-1:0];
                    end
                end
                MODE_PP: begin
                    if (!dir) begin
                        if (sum >= lim_x) begin
                            next_count = limit;
                            next_dir   = 1'b1;
                            next_tc    = 1'b1;
                        end else begin
                            next_count = sum[WIDTH-1:0];
                        end
                    end else begin
                        if (cnt_x <= s) begin
                            next_count = '0;
                            next_dir   = 1'b0;
                            next_tc    = 1'b1;
                        end else begin
                            next_count = diff[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    next_count = count;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= WIDTH'(RESET_VAL);
            dir   <= 1'b0;
            tc    <= 1'b0;
        end else if (load) begin
            count <= load_val;
            tc    <= 1'b0;
        end else begin
            count <= next_count;
            dir   <= next_dir;
            tc    <= next_tc;
        end
    end

`ifdef PARAM_COUNTER_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_val <= '0;
        end else if (capture) begin
            cap_val <= count;
        end
    end
`else
    logic unused_capture;
    assign unused_capture = capture;
    assign cap_val        = '0;
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench: directed scenarios plus randomized traffic against an integer model.
module tb_param_updown_counter;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned STEP_W    = 4;
    localparam int unsigned PRESC_W   = 4;
    localparam int unsigned RESET_VAL = 0;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               load;
    logic [WIDTH-1:0]   load_val;
    logic [1:0]         mode;
    logic [STEP_W-1:0]  step;
    logic [WIDTH-1:0]   limit;
    logic [PRESC_W-1:0] presc;
    logic               capture;
    logic [WIDTH-1:0]   count;
    logic               dir;
    logic               tc;
    logic [WIDTH-1:0]   cap_val;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    int m_cnt, m_dir, m_tc, m_cap, m_pre;

    always #5 clk = ~clk;

    param_updown_counter #(
        .WIDTH     (WIDTH),
        .STEP_W    (STEP_W),
        .PRESC_W   (PRESC_W),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
        .step     (step),
        .limit    (limit),
        .presc    (presc),
        .capture  (capture),
        .count    (count),
        .dir      (dir),
        .tc       (tc),
        .cap_val  (cap_val)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_cnt = RESET_VAL; m_dir = 0; m_tc = 0; m_cap = 0; m_pre = 0;
    endtask

    // Applies the counting rules to the inputs present at this clock edge.
    task automatic model_edge();
        int s, lim, pv;
        bit adv;
        s   = (step == 0) ? 1 : int'(step);
        lim = int'(limit);
        pv  = int'(presc);
`ifdef PARAM_COUNTER_CAPTURE_EN
        if (capture) m_cap = m_cnt;
`endif
        if (load) begin
            m_cnt = int'(load_val); m_pre = 0; m_tc = 0;
            return;
        end
        adv = en && (m_pre == pv);
        if (m_pre > pv) m_pre = 0;
        else if (en) m_pre = adv ? 0 : m_pre + 1;
        m_tc = 0;
        if (adv) begin
            case (mode)
                2'd0: begin
                    m_dir = 0;
                    if (m_cnt + s > lim) begin m_cnt = 0; m_tc = 1; end
                    else m_cnt = m_cnt + s;
                end
                2'd1: begin
                    m_dir = 0;
                    if (m_cnt < s) begin m_cnt = lim; m_tc = 1; end
                    else m_cnt = m_cnt - s;
                end
                2'd2: begin
                    if (m_dir == 0) begin
                        if (m_cnt + s >= lim) begin m_cnt = lim; m_dir = 1; m_tc = 1; end
                        else m_cnt = m_cnt + s;
                    end else begin
                        if (m_cnt <= s) begin m_cnt = 0; m_dir = 0; m_tc = 1; end
                        else m_cnt = m_cnt - s;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("count", int'(count), m_cnt);
        check("dir", int'(dir), m_dir);
        check("tc", int'(tc), m_tc);
        check("cap_val", int'(cap_val), m_cap);
    endtask

    initial begin
        int exp_c[$], exp_d[$], exp_t[$];
        int cap_exp;

        rst_n = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; mode = 2'd0;
        step = '0; limit = '0; presc = '0; capture = 1'b0;
        model_reset();
        #1;
        check("reset_count", int'(count), RESET_VAL);
        check("reset_dir", int'(dir), 0);
        check("reset_tc", int'(tc), 0);
        check("reset_cap", int'(cap_val), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: up-wrap at limit 9
        mode = 2'd0; limit = 8'd9; step = 4'd1; presc = '0; en = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            cycle();
            check("t1_count", int'(count), i % 10);
            check("t1_tc", int'(tc), (i == 10) ? 1 : 0);
        end

        // 2: down-wrap from 4 by 3 under limit 20
        mode = 2'd1; limit = 8'd20; step = 4'd3; load = 1'b1; load_val = 8'd4;
        cycle();
        check("t2_load", int'(count), 4);
        load = 1'b0;
        exp_c = '{1, 20, 17}; exp_t = '{0, 1, 0};
        foreach (exp_c[i]) begin
            cycle();
            check("t2_count", int'(count), exp_c[i]);
            check("t2_tc", int'(tc), exp_t[i]);
        end

        // 3: ping-pong between 0 and 5, step 2
        mode = 2'd2; limit = 8'd5; step = 4'd2; load = 1'b1; load_val = 8'd0;
        cycle();
        check("t3_load", int'(count), 0);
        load = 1'b0;
        exp_c = '{2, 4, 5, 3, 1, 0, 2};
        exp_d = '{0, 0, 1, 1, 1, 0, 0};
        exp_t = '{0, 0, 1, 0, 0, 1, 0};
        foreach (exp_c[i]) begin
            cycle();
            check("t3_count", int'(count), exp_c[i]);
            check("t3_dir", int'(dir), exp_d[i]);
            check("t3_tc", int'(tc), exp_t[i]);
        end

        // 4: prescale by 4, then stretch one interval by dropping en twice
        mode = 2'd0; limit = 8'd200; step = 4'd1; presc = 4'd3; load = 1'b1; load_val = 8'd0;
        cycle();
        load = 1'b0;
        repeat (3) cycle();
        check("t4_before_tick", int'(count), 0);
        cycle();
        check("t4_tick", int'(count), 1);
        cycle();
        en = 1'b0;
        repeat (2) cycle();
        en = 1'b1;
        repeat (2) cycle();
        check("t4_stretched", int'(count), 1);
        cycle();
        check("t4_stretched_tick", int'(count), 2);

        // 5: load beats en; async reset mid-count
        presc = '0; load = 1'b1; load_val = 8'hAA;
        cycle();
        check("t5_load", int'(count), 8'hAA);
        check("t5_no_tc", int'(tc), 0);
        load = 1'b0;
        cycle();
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_count", int'(count), RESET_VAL);
        check("t5_async_dir", int'(dir), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // 6: capture at count 7 during an up-count
        mode = 2'd0; limit = 8'd50; step = 4'd1; load = 1'b1; load_val = 8'd5;
        cycle();
        load = 1'b0;
        repeat (2) cycle();
        capture = 1'b1;
        cycle();
        capture = 1'b0;
`ifdef PARAM_COUNTER_CAPTURE_EN
        cap_exp = 7;
`else
        cap_exp = 0;
`endif
        check("t6_count", int'(count), 8);
        check("t6_cap", int'(cap_val), cap_exp);

        // Randomized traffic across modes, limits, steps and prescaler changes
        for (int i = 0; i < 3000; i++) begin
            load     = ($urandom_range(0, 15) == 0);
            load_val = 8'($urandom);
            en       = ($urandom_range(0, 3) != 0);
            capture  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 29) == 0)
                limit = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 9) == 0) step = 4'($urandom);
            if ($urandom_range(0, 39) == 0)
                presc = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
